tpn_stream_reader: RTL and testbench

- Consumer end of the true-page-number (TPN) array that the bit-pattern finder produces.
- Input: a packed array of NOP_WIDTH-bit page indices, entry 0 at bits [NOP_WIDTH-1:0], plus the bit-offset fill level the finder accumulated.
- On start, snapshots both and streams the indices one per valid/ready handshake to the page-fetch logic.
- Each index is paired with its bit offset in the input vector, a last flag and a range-error flag.

---
 rtl/tpn_stream_reader.sv | 150 +++++++++++++++
 tb/tb_tpn_stream_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tpn_stream_reader.sv
// Streams a snapshot of the packed true-page-number array one entry per
// valid/ready handshake, tagging each entry with its bit offset, last and range-error flags.
module tpn_stream_reader #(
  parameter int NOP        = 24,
  parameter int NOP_WIDTH  = 5,
  parameter int P_SIZE     = 12,
  parameter int OFS_WIDTH  = 7,
  parameter int BOFS_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NOP*NOP_WIDTH-1:0]  tpn_arr,
  input  logic [OFS_WIDTH-1:0]      tpn_ofs,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NOP_WIDTH-1:0]      out_tpn,
  output logic [BOFS_WIDTH-1:0]     out_bit_ofs,
  output logic                      out_last,
  output logic                      out_err,
  output logic                      busy,
  output logic                      done,
  output logic [NOP_WIDTH-1:0]      emit_cnt,
  output logic                      err_align
);

  localparam int ARR_W = NOP * NOP_WIDTH;
  localparam int CMP_W = OFS_WIDTH + 2;
  localparam logic [OFS_WIDTH-1:0] MAX_OFS  = OFS_WIDTH'(ARR_W);
  localparam logic [OFS_WIDTH-1:0] STEP     = OFS_WIDTH'(NOP_WIDTH);
  localparam logic [CMP_W-1:0]     LOOKAHEAD = CMP_W'(2 * NOP_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [ARR_W-1:0]       arr_snap;
  logic [OFS_WIDTH-1:0]   ofs_c;
  logic [OFS_WIDTH-1:0]   ptr;

  logic [OFS_WIDTH-1:0]   ofs_clamp;
  logic                   misalign;
  logic [NOP_WIDTH-1:0]   entry;
  logic                   entry_last;
  logic                   entry_err;
  logic [BOFS_WIDTH-1:0]  entry_bofs;

  // Start-time conditioning: clamp the fill level and flag misaligned or oversized input.
  always_comb begin
    if (tpn_ofs > MAX_OFS) begin
      ofs_clamp = MAX_OFS;
      misalign  = 1'b1;
    end else begin
      ofs_clamp = tpn_ofs;
      misalign  = ((tpn_ofs % STEP) != {OFS_WIDTH{1'b0}});
    end
  end

  // Current entry and its derived fields, all from registered snapshot state.
  always_comb begin
    entry      = arr_snap[ptr +: NOP_WIDTH];
    entry_last = (({2'b00, ptr} + LOOKAHEAD) > {2'b00, ofs_c});
    entry_err  = ({1'b0, entry} >= (NOP_WIDTH + 1)'(NOP));
    if (entry_err) begin
      entry_bofs = {BOFS_WIDTH{1'b0}};
    end else begin
      entry_bofs = BOFS_WIDTH'(entry) * BOFS_WIDTH'(P_SIZE);
    end
  end

  // Next-state logic and state-decoded outputs; out_* fields are zero outside STREAM.
  always_comb begin
    state_nx    = state;
    out_valid   = 1'b0;
    out_tpn     = {NOP_WIDTH{1'b0}};
    out_bit_ofs = {BOFS_WIDTH{1'b0}};
    out_last    = 1'b0;
    out_err     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (ofs_clamp >= STEP) ? STREAM : DONE;
        end else begin
          state_nx = IDLE;
        end
      end
      STREAM: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        out_tpn     = entry;
        out_bit_ofs = entry_bofs;
        out_last    = entry_last;
        out_err     = entry_err;
        if (out_ready && entry_last) begin
          state_nx = DONE;
        end else begin
          state_nx = STREAM;
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, snapshot, pointer and pass counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arr_snap  <= {ARR_W{1'b0}};
      ofs_c     <= {OFS_WIDTH{1'b0}};
      ptr       <= {OFS_WIDTH{1'b0}};
      emit_cnt  <= {NOP_WIDTH{1'b0}};
      err_align <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            arr_snap  <= tpn_arr;
            ofs_c     <= ofs_clamp;
            ptr       <= {OFS_WIDTH{1'b0}};
            emit_cnt  <= {NOP_WIDTH{1'b0}};
            err_align <= misalign;
          end
        end
        STREAM: begin
          if (out_ready) begin
            ptr      <= ptr + STEP;
            emit_cnt <= emit_cnt + NOP_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpn_stream_reader.sv
// Scoreboard bench for tpn_stream_reader: expected entries are queued at start
// and compared against each observed handshake.
module tb_tpn_stream_reader;

  localparam int NOP = 24;
  localparam int NW  = 5;
  localparam int PS  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [119:0]  tpn_arr;
  logic [6:0]    tpn_ofs;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_tpn;
  logic [8:0]    out_bit_ofs;
  logic          out_last;
  logic          out_err;
  logic          busy;
  logic          done;
  logic [4:0]    emit_cnt;
  logic          err_align;

  typedef struct {
    logic [4:0] tpn;
    logic [8:0] bofs;
    logic       last;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  tpn_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .tpn_arr(tpn_arr), .tpn_ofs(tpn_ofs),
    .out_valid(out_valid), .out_ready(out_ready), .out_tpn(out_tpn),
    .out_bit_ofs(out_bit_ofs), .out_last(out_last), .out_err(out_err),
    .busy(busy), .done(done), .emit_cnt(emit_cnt), .err_align(err_align)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whole entries that fit in the clamped fill level.
  task automatic push_expected(input logic [119:0] arr, input int ofs);
    int   clamp;
    exp_t e;
    clamp = (ofs > NOP * NW) ? NOP * NW : ofs;
    for (int k = 0; k < NOP; k++) begin
      if ((k + 1) * NW <= clamp) begin
        e.tpn  = arr[k*NW +: NW];
        e.err  = (e.tpn >= NOP);
        e.bofs = e.err ? 9'd0 : 9'(e.tpn * PS);
        e.last = ((k + 2) * NW > clamp);
        sb.push_back(e);
      end
    end
  endtask

  // Pulses start with arr/ofs, then scrambles the inputs to prove the snapshot.
  task automatic do_start(input logic [119:0] arr, input logic [6:0] ofs);
    @(posedge clk); #1;
    tpn_arr = arr;
    tpn_ofs = ofs;
    start   = 1'b1;
    push_expected(arr, int'(ofs));
    @(posedge clk); #1;
    start   = 1'b0;
    tpn_arr = {$urandom, $urandom, $urandom, $urandom};
    tpn_ofs = 7'($urandom);
  endtask

  task automatic wait_done(input int exp_cnt, input bit exp_al, input bit rnd);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("emit_cnt", 32'(emit_cnt), 32'(exp_cnt));
    check("err_align", 32'(err_align), 32'(exp_al));
    check("sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Handshake monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexp_xfer", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("x_tpn", 32'(out_tpn), 32'(mon_e.tpn));
        check("x_bofs", 32'(out_bit_ofs), 32'(mon_e.bofs));
        check("x_last", 32'(out_last), 32'(mon_e.last));
        check("x_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    logic [119:0] a;
    logic [119:0] b;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; tpn_arr = '0; tpn_ofs = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outs", 32'({out_valid, out_tpn, out_bit_ofs, out_last, out_err,
                           busy, done, emit_cnt, err_align}), 32'd0);

    // Two-entry pass, exact cycle timing
    a = '0; a[4:0] = 5'd3; a[9:5] = 5'd17;
    out_ready = 1'b1;
    do_start(a, 7'd10);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_tpn0", 32'(out_tpn), 32'd3);
    check("t1_bofs0", 32'(out_bit_ofs), 32'd36);
    check("t1_last0", 32'(out_last), 32'd0);
    @(negedge clk);
    check("t1_tpn1", 32'(out_tpn), 32'd17);
    check("t1_bofs1", 32'(out_bit_ofs), 32'd204);
    check("t1_last1", 32'(out_last), 32'd1);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_novalid", 32'(out_valid), 32'd0);
    check("t1_cnt", 32'(emit_cnt), 32'd2);
    check("t1_align", 32'(err_align), 32'd0);
    @(negedge clk);
    check("t1_idle", 32'({busy, done}), 32'd0);
    check("t1_sb", 32'(sb.size()), 32'd0);

    // Backpressure: fields held while out_ready is low
    out_ready = 1'b0;
    do_start(a, 7'd10);
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_tpn", 32'(out_tpn), 32'd3);
      check("bp_bofs", 32'(out_bit_ofs), 32'd36);
    end
    wait_done(2, 1'b0, 1'b0);

    // Empty pass
    do_start('0, 7'd0);
    @(negedge clk);
    check("e_done", 32'(done), 32'd1);
    check("e_valid", 32'(out_valid), 32'd0);
    check("e_cnt", 32'(emit_cnt), 32'd0);
    check("e_align", 32'(err_align), 32'd0);
    @(negedge clk);

    // Misaligned fill: only whole entry emitted
    a = '0; a[4:0] = 5'd9; a[9:5] = 5'd11;
    do_start(a, 7'd7);
    wait_done(1, 1'b1, 1'b0);

    // Full array with clamped oversized fill level, random ready
    for (int k = 0; k < NOP; k++) a[k*NW +: NW] = 5'(k);
    do_start(a, 7'd127);
    wait_done(24, 1'b1, 1'b1);

    // Over-range entries still emitted and counted
    a = '0; a[4:0] = 5'd25; a[9:5] = 5'd31; a[14:10] = 5'd4;
    do_start(a, 7'd15);
    wait_done(3, 1'b0, 1'b1);

    // Start while busy is ignored
    out_ready = 1'b0;
    a = '0; a[4:0] = 5'd1; a[9:5] = 5'd2; a[14:10] = 5'd22; a[19:15] = 5'd7;
    do_start(a, 7'd20);
    b = '1;
    tpn_arr = b; tpn_ofs = 7'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(4, 1'b0, 1'b0);

    // Reset mid-pass under backpressure, then a fresh pass
    out_ready = 1'b0;
    a = '0; a[4:0] = 5'd3; a[9:5] = 5'd17;
    do_start(a, 7'd10);
    @(negedge clk);
    check("r_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("r_outs", 32'({out_valid, out_tpn, out_bit_ofs, out_last, out_err,
                         busy, done, emit_cnt, err_align}), 32'd0);
    rst = 1'b0;
    sb.delete();
    a = '0; a[4:0] = 5'd20; a[9:5] = 5'd23; a[14:10] = 5'd0;
    do_start(a, 7'd15);
    wait_done(3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
